// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed seven-segment display path.
// Glyphs are active-low {g,f,e,d,c,b,a} for a common-anode display.
package seg7_pkg;

    localparam int MAX_DIGITS = 8;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Index 0 is the rightmost entry of the concatenation.
    localparam logic [15:0][6:0] HEX_GLYPH = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment glyph lookup.
module hex_to_seg7 (
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);
    import seg7_pkg::*;

    assign o_seg = HEX_GLYPH[i_nib];

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed common-anode seven-segment scanner with per-frame snapshot,
// leading-zero blanking, decimal points and an inter-digit dead time.
module seg7_scan #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int DEAD        = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_mask,
    input  logic                  blank_lz,
    input  logic                  enable,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  frame_tick
);
    import seg7_pkg::*;

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_DEAD = CNT_W'(DEAD);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [CNT_W-1:0]    r_cnt;
    logic [IDX_W-1:0]    r_idx;
    logic [4*DIGITS-1:0] r_val_sh;
    logic [DIGITS-1:0]   r_dp_sh;

    logic                w_cnt_wrap;
    logic                w_snap;
    logic [DIGITS-1:0]   w_blanked;
    logic                w_zero_run;
    logic [3:0]          w_nib;
    logic [6:0]          w_glyph;
    logic                w_blank_sel;
    logic                w_dp_sel;
    logic                w_active;
    logic [DIGITS-1:0]   w_an;

    assign w_cnt_wrap = (r_cnt == CNT_LAST);
    assign w_snap     = w_cnt_wrap && (r_idx == IDX_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_cnt_wrap) begin
            r_cnt <= '0;
            r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Inputs are only captured on the last cycle of a frame so digits never tear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_val_sh   <= '0;
            r_dp_sh    <= '0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= w_snap;
            if (w_snap) begin
                r_val_sh <= value;
                r_dp_sh  <= dp_mask;
            end
        end
    end

    always_comb begin
        w_blanked  = '0;
        w_zero_run = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            w_zero_run = w_zero_run && (r_val_sh[4*k +: 4] == 4'h0);
            if (k > 0) begin
                w_blanked[k] = blank_lz && w_zero_run;
            end
        end
    end

    always_comb begin
        w_nib       = 4'h0;
        w_blank_sel = 1'b0;
        w_dp_sel    = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_nib       = r_val_sh[4*k +: 4];
                w_blank_sel = w_blanked[k];
                w_dp_sel    = r_dp_sh[k];
            end
        end
    end

    hex_to_seg7 u_hex_to_seg7 (
        .i_nib (w_nib),
        .o_seg (w_glyph)
    );

    // A blanked digit is still driven when its decimal point is lit.
    assign w_active = enable && (r_cnt >= CNT_DEAD) && !(w_blank_sel && !w_dp_sel);

    always_comb begin
        w_an = '1;
        for (int k = 0; k < DIGITS; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_an[k] = !w_active;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            an  <= '1;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= w_an;
            seg <= w_blank_sel ? SEG_BLANK : w_glyph;
            dp  <= !w_dp_sel;
        end
    end

endmodule

// File: tb/tb_seg7_scan.sv
// Directed self-checking bench for seg7_scan with DIGITS=4, REFRESH_DIV=8, DEAD=2.
module tb_seg7_scan;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value;
    logic [3:0]  dp_mask;
    logic        blank_lz;
    logic        enable;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_tick;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seg7_scan #(
        .DIGITS      (4),
        .REFRESH_DIV (8),
        .DEAD        (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .value      (value),
        .dp_mask    (dp_mask),
        .blank_lz   (blank_lz),
        .enable     (enable),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_off(input string tag);
        chk({tag, " an"},   {4'h0, an},         8'h0F);
        chk({tag, " seg"},  {1'b0, seg},        8'h7F);
        chk({tag, " dp"},   {7'h0, dp},         8'h01);
        chk({tag, " tick"}, {7'h0, frame_tick}, 8'h00);
    endtask

    // One clock; outputs then reflect slot cycle c of digit idx.
    task automatic cyc(input int idx, input int c, input logic [6:0] glyph,
                       input bit drive, input bit dpl, input bit tick);
        logic       en_s;
        logic [3:0] exp_an;
        en_s = enable;
        @(posedge clk);
        #1;
        exp_an = 4'hF;
        if (drive && en_s && c >= 2) exp_an[idx] = 1'b0;
        chk($sformatf("an d%0d c%0d", idx, c),   {4'h0, an},         {4'h0, exp_an});
        chk($sformatf("seg d%0d c%0d", idx, c),  {1'b0, seg},        {1'b0, glyph});
        chk($sformatf("dp d%0d c%0d", idx, c),   {7'h0, dp},         {7'h0, !dpl});
        chk($sformatf("tick d%0d c%0d", idx, c), {7'h0, frame_tick}, {7'h0, tick});
    endtask

    task automatic slot(input int idx, input logic [6:0] glyph, input bit drive,
                        input bit dpl, input bit last);
        for (int c = 0; c < 8; c++) cyc(idx, c, glyph, drive, dpl, last && (c == 7));
    endtask

    task automatic frame(input logic [27:0] glyphs, input logic [3:0] drv, input logic [3:0] dpl);
        for (int k = 0; k < 4; k++) slot(k, glyphs[7*k +: 7], drv[k], dpl[k], k == 3);
    endtask

    initial begin
        rst      = 1'b0;
        value    = 16'h12AF;
        dp_mask  = 4'b0000;
        blank_lz = 1'b0;
        enable   = 1'b1;
        repeat (2) @(negedge clk);
        chk_off("reset");
        rst = 1'b1;

        // Zero shadow for the first frame, then 12AF.
        frame({7'h40, 7'h40, 7'h40, 7'h40}, 4'hF, 4'h0);
        frame({7'h79, 7'h24, 7'h08, 7'h0E}, 4'hF, 4'h0);

        // A change right after a snapshot waits a whole frame.
        value = 16'h1111;
        frame({7'h79, 7'h24, 7'h08, 7'h0E}, 4'hF, 4'h0);

        slot(0, 7'h79, 1'b1, 1'b0, 1'b0);
        value = 16'h2222;
        slot(1, 7'h79, 1'b1, 1'b0, 1'b0);
        slot(2, 7'h79, 1'b1, 1'b0, 1'b0);
        slot(3, 7'h79, 1'b1, 1'b0, 1'b1);

        slot(0, 7'h24, 1'b1, 1'b0, 1'b0);
        value = 16'h0000;
        slot(1, 7'h24, 1'b1, 1'b0, 1'b0);
        slot(2, 7'h24, 1'b1, 1'b0, 1'b0);
        slot(3, 7'h24, 1'b1, 1'b0, 1'b1);

        // Leading-zero blanking; then a lit dp keeps blanked digit 2 driven.
        blank_lz = 1'b1;
        dp_mask  = 4'b0100;
        frame({7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b0001, 4'b0000);
        frame({7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b0101, 4'b0100);

        // Enable dropped at cnt=4, restored at cnt=5.
        for (int c = 0; c < 8; c++) begin
            if (c == 4) enable = 1'b0;
            if (c == 5) enable = 1'b1;
            cyc(0, c, 7'h40, 1'b1, 1'b0, 1'b0);
        end
        slot(1, 7'h7F, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 5; c++) cyc(2, c, 7'h7F, 1'b1, 1'b1, 1'b0);

        // Asynchronous reset at cnt=5 of digit 2.
        rst = 1'b0;
        #1;
        chk_off("async rst");
        value    = 16'hFEDC;
        dp_mask  = 4'b1001;
        blank_lz = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;

        frame({7'h40, 7'h40, 7'h40, 7'h40}, 4'hF, 4'h0);
        frame({7'h0E, 7'h06, 7'h21, 7'h46}, 4'hF, 4'b1001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
